// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package seven_seg_scan_controller_pkg;

    localparam int unsigned SCAN_DIV_DEFAULT     = 50000;
    localparam int unsigned BLANK_CYCLES_DEFAULT = 64;
    localparam int unsigned NIB_W                = 4;
    localparam int unsigned MAX_DIGITS           = 16;

    // Drive presented to the shared decoder for one slot evaluation.
    typedef struct packed {
        logic [NIB_W-1:0] x;
        logic             en;
    } dec_drive_t;

    // Nibble i of a packed value (digit 0 in the least significant nibble).
    function automatic logic [NIB_W-1:0] nib(input logic [NIB_W*MAX_DIGITS-1:0] v, input int i);
        return v[NIB_W*i +: NIB_W];
    endfunction

endpackage

// File: rtl/seven_seg_scan_controller_scan_tick_gen.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and flags the wrap and the dead-time window.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV     = 8,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned DIV_WIDTH    = 16
) (
    input  logic clk,
    input  logic reset,
    output logic slot_tick,
    output logic in_blank
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // Wrap and blank flags decoded from the current count.
    always_comb begin
        slot_tick = (cnt_q == DIV_WIDTH'(SCAN_DIV - 1));
        in_blank  = (cnt_q < DIV_WIDTH'(BLANK_CYCLES));
        cnt_d     = slot_tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Multiplexes NUM_DIGITS common-anode digits onto one shared decoder, with a
// frame-synchronous double buffer, per-digit enables and leading-zero blanking.
module seven_seg_scan_controller
    import seven_seg_scan_controller_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEFAULT,
    parameter int unsigned DIV_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NIB_W*NUM_DIGITS-1:0] value_in,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic                        lz_suppress,
    output logic [NIB_W-1:0]            dec_x,
    output logic                        dec_en,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done
);

    localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic slot_tick;
    logic in_blank;

    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [VAL_W-1:0]      active_q,   active_d;
    logic [VAL_W-1:0]      pending_q,  pending_d;
    logic                  pend_vld_q, pend_vld_d;
    dec_drive_t            dec_q,      dec_d;
    logic [NUM_DIGITS-1:0] an_n_q,     an_n_d;
    logic                  frame_q,    frame_d;

    logic                  boundary_c;
    logic                  zero_run_c;
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [NIB_W-1:0]      cur_nib_c;

    scan_tick_gen #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DIV_WIDTH    (DIV_WIDTH)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .slot_tick (slot_tick),
        .in_blank  (in_blank)
    );

    // Digit index, double buffer, leading-zero mask and next output drive.
    always_comb begin
        idx_d      = idx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        zero_run_c = 1'b1;
        lz_blank_c = '0;

        boundary_c = slot_tick && (idx_q == LAST_IDX);

        if (slot_tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        // A load landing on the boundary bypasses pending; newest load always wins.
        if (boundary_c) begin
            if (load) begin
                active_d   = value_in;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
            end
        end else if (load) begin
            pending_d  = value_in;
            pend_vld_d = 1'b1;
        end

        // Blank a digit only if it and every more significant digit are zero.
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c    = zero_run_c && (nib(64'(active_q), i) == '0);
            lz_blank_c[i] = lz_suppress && zero_run_c;
        end
        lz_blank_c[0] = 1'b0;

        cur_nib_c = nib(64'(active_q), int'(idx_q));

        dec_d.x = cur_nib_c;
        if (in_blank) begin
            an_n_d   = '1;
            dec_d.en = 1'b0;
        end else begin
            an_n_d   = ~(NUM_DIGITS'(1) << idx_q);
            dec_d.en = digit_en[idx_q] && !lz_blank_c[idx_q];
        end
        frame_d = boundary_c;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            dec_q      <= '0;
            an_n_q     <= '1;
            frame_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            dec_q      <= dec_d;
            an_n_q     <= an_n_d;
            frame_q    <= frame_d;
        end
    end

    assign dec_x      = dec_q.x;
    assign dec_en     = dec_q.en;
    assign an_n       = an_n_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench for seven_seg_scan_controller (4 digits, 8-cycle slots, 2-cycle dead time).
module tb_seven_seg_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic [3:0]  dec_x;
    logic        dec_en;
    logic [3:0]  an_n;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] an_n;
        logic       en;
        logic [3:0] x;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_scan_controller #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .DIV_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .dec_x       (dec_x),
        .dec_en      (dec_en),
        .an_n        (an_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One frame of stimulus; called and returns just after a frame-start edge.
    task automatic run_frame(input logic [15:0] exp_val, input logic [3:0] exp_en,
                             input logic [3:0] den, input logic lz,
                             input int la, input logic [15:0] lva,
                             input int lb, input logic [15:0] lvb);
        exp_t e;
        digit_en    = den;
        lz_suppress = lz;
        for (int d = 0; d < 4; d++) begin
            e.an_n = ~(4'(1) << d);
            e.en   = exp_en[d];
            e.x    = exp_val[4*d +: 4];
            exp_q.push_back(e);
        end
        for (int off = 0; off < 32; off++) begin
            if (off == la) begin
                load = 1'b1; value_in = lva;
            end else if (off == lb) begin
                load = 1'b1; value_in = lvb;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
    endtask

    // Posedges since reset release.
    int pos_cnt = 0;
    initial forever begin
        @(posedge clk);
        if (reset) pos_cnt = 0;
        else       pos_cnt = pos_cnt + 1;
    end

    // Monitor: pops one expectation at the start of every lit slot, checks slot timing.
    initial begin
        int   last_fd;
        int   blank_run;
        int   lit_run;
        exp_t e;
        last_fd = 0; blank_run = 0; lit_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_fd = 0; blank_run = 0; lit_run = 0;
            end else if (pos_cnt > 0) begin
                if (frame_done) begin
                    check("frame_period", pos_cnt - last_fd, 32);
                    last_fd = pos_cnt;
                end
                if (an_n == 4'hF) begin
                    check("blank_dec_en", 32'(dec_en), 0);
                    if (lit_run > 0) check("lit_len", lit_run, 6);
                    lit_run = 0;
                    blank_run++;
                end else begin
                    check("one_anode", $countones(~an_n), 1);
                    if (lit_run == 0) begin
                        check("blank_len", blank_run, 2);
                        blank_run = 0;
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("an_n",   32'(an_n),   32'(e.an_n));
                            check("dec_en", 32'(dec_en), 32'(e.en));
                            check("dec_x",  32'(dec_x),  32'(e.x));
                        end
                    end
                    lit_run++;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; value_in = '0; digit_en = 4'hF; lz_suppress = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an_n",   32'(an_n),       32'hF);
        check("rst_dec_en", 32'(dec_en),     0);
        check("rst_dec_x",  32'(dec_x),      0);
        check("rst_fdone",  32'(frame_done), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // idle scan, then mid-frame load held until the boundary
        run_frame(16'h0000, 4'hF, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h0000, 4'hF, 4'hF, 1'b0, 13, 16'h1234, -1, 16'h0);
        run_frame(16'h1234, 4'hF, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);
        // leading-zero suppression
        run_frame(16'h1234, 4'hF, 4'hF, 1'b1, 5, 16'h0070, -1, 16'h0);
        run_frame(16'h0070, 4'b0011, 4'hF, 1'b1, 10, 16'h0000, -1, 16'h0);
        run_frame(16'h0000, 4'b0001, 4'hF, 1'b1, 3, 16'hAAAA, 20, 16'h5555);
        // newest load wins; load on the boundary cycle shows in the next frame
        run_frame(16'h5555, 4'hF, 4'hF, 1'b0, 31, 16'h9876, -1, 16'h0);
        run_frame(16'h9876, 4'b0101, 4'b0101, 1'b0, -1, 16'h0, -1, 16'h0);

        // pending load, then asynchronous reset mid-slot
        digit_en = 4'hF;
        for (int off = 0; off < 13; off++) begin
            load     = (off == 5);
            value_in = 16'h4321;
            @(posedge clk); #1;
        end
        load = 1'b0;
        check("pre_rst_an_n",   32'(an_n),   32'b1101);
        check("pre_rst_dec_en", 32'(dec_en), 1);
        check("pre_rst_dec_x",  32'(dec_x),  32'h7);
        #2 reset = 1'b1;
        #1;
        check("async_an_n",   32'(an_n),       32'hF);
        check("async_dec_en", 32'(dec_en),     0);
        check("async_dec_x",  32'(dec_x),      0);
        check("async_fdone",  32'(frame_done), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run_frame(16'h0000, 4'hF, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h0000, 4'hF, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
